// File: rtl/ahb_decoder_mux_pkg.sv
// Shared AHB-Lite types for the decoder/response mux and its default slave.
package AHB_package;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } hresp_type;

    typedef enum logic [1:0] {
        DS_OK   = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    function automatic logic is_active(input htrans_type t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/ahb_decoder_mux_default_slave.sv
// Default slave: two-cycle ERROR for accepted unmapped NONSEQ/SEQ transfers,
// plus a saturating count of those errors.
module ahb_default_slave
    import AHB_package::*;
#(
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic                     hready,
    input  logic                     unmapped_active,
    output logic                     ds_hready,
    output logic                     ds_hresp,
    output logic [ERR_CNT_WIDTH-1:0] dec_err_cnt
);

    ds_state_t                state_q, state_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
    hresp_type                resp;
    logic                     err_start;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= DS_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ds_hready = 1'b1;
        resp      = OKAY;
        err_start = 1'b0;
        case (state_q)
            DS_OK: begin
                if (hready && unmapped_active) begin
                    state_d   = DS_ERR1;
                    err_start = 1'b1;
                end
            end
            DS_ERR1: begin
                ds_hready = 1'b0;
                resp      = ERROR;
                state_d   = DS_ERR2;
            end
            DS_ERR2: begin
                resp = ERROR;
                // A new unmapped transfer here chains straight into the next error
                if (hready && unmapped_active) begin
                    state_d   = DS_ERR1;
                    err_start = 1'b1;
                end else begin
                    state_d = DS_OK;
                end
            end
            default: state_d = DS_OK;
        endcase

        cnt_d = cnt_q;
        if (err_start && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    assign ds_hresp    = resp;
    assign dec_err_cnt = cnt_q;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder with boot remap and data-phase slave response mux
// for a single master port; unmapped transfers fall through to the default slave.
module ahb_decoder_mux
    import AHB_package::*;
#(
    parameter int unsigned SLV_NUM        = 4,
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter logic [SLV_NUM-1:0][AHB_ADDR_WIDTH-1:0] LOW_ADDR =
        {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [SLV_NUM-1:0][AHB_ADDR_WIDTH-1:0] HIGH_ADDR =
        {32'h4000_0FFF, 32'h2FFF_FFFF, 32'h1000_FFFF, 32'h0000_FFFF},
    parameter int unsigned REMAP_SLV      = 1,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input  logic                              hclk,
    input  logic                              hreset,
    input  logic [AHB_ADDR_WIDTH-1:0]         haddr,
    input  htrans_type                        htrans,
    input  logic                              hremap,
    input  logic                              hready,
    output logic [SLV_NUM-1:0]                hsel,
    input  logic [SLV_NUM*AHB_DATA_WIDTH-1:0] s_hrdata,
    input  logic [SLV_NUM-1:0]                s_hreadyout,
    input  logic [SLV_NUM-1:0]                s_hresp,
    output logic [AHB_DATA_WIDTH-1:0]         hrdata,
    output logic                              hready_out,
    output logic                              hresp,
    output logic [ERR_CNT_WIDTH-1:0]          dec_err_cnt
);

    localparam int unsigned        SEL_W       = $clog2(SLV_NUM + 1);
    localparam logic [SEL_W-1:0]   SEL_DEFAULT = SEL_W'(SLV_NUM);

    logic             hit;
    logic [SEL_W-1:0] sel_d, sel_dp_q;
    logic             unmapped_active;
    logic             ds_hready, ds_hresp;

    // Range test as (haddr - LOW) <= (HIGH - LOW): one unsigned compare per region,
    // valid because every region has LOW <= HIGH. Lowest matching index wins.
    always_comb begin
        hit   = 1'b0;
        sel_d = SEL_DEFAULT;
        for (int unsigned i = 0; i < SLV_NUM; i++) begin
            if (!hit && ((haddr - LOW_ADDR[i]) <= (HIGH_ADDR[i] - LOW_ADDR[i]))) begin
                hit   = 1'b1;
                sel_d = SEL_W'(i);
            end
        end
        if (hit && hremap && (sel_d == '0)) begin
            sel_d = SEL_W'(REMAP_SLV);
        end
        hsel = '0;
        for (int unsigned i = 0; i < SLV_NUM; i++) begin
            hsel[i] = (sel_d == SEL_W'(i));
        end
    end

    assign unmapped_active = !hit && is_active(htrans);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            sel_dp_q <= SEL_DEFAULT;
        end else if (hready) begin
            sel_dp_q <= sel_d;
        end
    end

    always_comb begin
        hrdata     = '0;
        hready_out = ds_hready;
        hresp      = ds_hresp;
        for (int unsigned k = 0; k < SLV_NUM; k++) begin
            if (sel_dp_q == SEL_W'(k)) begin
                hrdata     = s_hrdata[k*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
                hready_out = s_hreadyout[k];
                hresp      = s_hresp[k];
            end
        end
    end

    ahb_default_slave #(
        .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
    ) u_default_slave (
        .hclk           (hclk),
        .hreset         (hreset),
        .hready         (hready),
        .unmapped_active(unmapped_active),
        .ds_hready      (ds_hready),
        .ds_hresp       (ds_hresp),
        .dec_err_cnt    (dec_err_cnt)
    );

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux: decode table plus data-phase/error sequences.
module tb_ahb_decoder_mux;
    import AHB_package::*;

    logic             hclk = 1'b0;
    logic             hreset;
    logic [31:0]      haddr;
    htrans_type       htrans;
    logic             hremap;
    logic             hready;
    logic [3:0]       hsel, hsel_ovl;
    logic [3:0][31:0] s_hrdata;
    logic [3:0]       s_hreadyout;
    logic [3:0]       s_hresp;
    logic [31:0]      hrdata, hrdata_ovl;
    logic             hready_out, hready_out_ovl;
    logic             hresp, hresp_ovl;
    logic [7:0]       dec_err_cnt, dec_err_cnt_ovl;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 hclk = ~hclk;
    assign hready = hready_out;

    ahb_decoder_mux u_dut (
        .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans), .hremap(hremap),
        .hready(hready), .hsel(hsel), .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout),
        .s_hresp(s_hresp), .hrdata(hrdata), .hready_out(hready_out), .hresp(hresp),
        .dec_err_cnt(dec_err_cnt)
    );

    // Slaves 1 and 2 share an identical window to exercise priority on overlap
    ahb_decoder_mux #(
        .LOW_ADDR ({32'h4000_0000, 32'h2000_0000, 32'h2000_0000, 32'h0000_0000}),
        .HIGH_ADDR({32'h4000_0FFF, 32'h2000_FFFF, 32'h2000_FFFF, 32'h0000_FFFF})
    ) u_ovl (
        .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans), .hremap(hremap),
        .hready(hready), .hsel(hsel_ovl), .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout),
        .s_hresp(s_hresp), .hrdata(hrdata_ovl), .hready_out(hready_out_ovl),
        .hresp(hresp_ovl), .dec_err_cnt(dec_err_cnt_ovl)
    );

    typedef struct {
        logic [31:0] addr;
        logic        remap;
        logic [3:0]  exp_hsel;
        logic [3:0]  exp_ovl;
    } dec_vec_t;

    dec_vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input htrans_type t, input logic r);
        haddr  = a;
        htrans = t;
        hremap = r;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h1000_0010, 1'b0, 4'b0010, 4'b0000};
        vecs[1]  = '{32'h2000_0000, 1'b0, 4'b0100, 4'b0010};
        vecs[2]  = '{32'h3000_0000, 1'b0, 4'b0000, 4'b0000};
        vecs[3]  = '{32'h0000_0100, 1'b1, 4'b0010, 4'b0010};
        vecs[4]  = '{32'h0000_0100, 1'b0, 4'b0001, 4'b0001};
        vecs[5]  = '{32'h0000_FFFF, 1'b0, 4'b0001, 4'b0001};
        vecs[6]  = '{32'h0001_0000, 1'b0, 4'b0000, 4'b0000};
        vecs[7]  = '{32'h1000_FFFF, 1'b0, 4'b0010, 4'b0000};
        vecs[8]  = '{32'h1001_0000, 1'b0, 4'b0000, 4'b0000};
        vecs[9]  = '{32'h2FFF_FFFF, 1'b0, 4'b0100, 4'b0000};
        vecs[10] = '{32'h2000_0100, 1'b0, 4'b0100, 4'b0010};
        vecs[11] = '{32'h4000_0FFF, 1'b0, 4'b1000, 4'b1000};
        vecs[12] = '{32'h4000_1000, 1'b0, 4'b0000, 4'b0000};
        vecs[13] = '{32'hFFFF_FFFF, 1'b0, 4'b0000, 4'b0000};
        vecs[14] = '{32'h0FFF_FFFF, 1'b0, 4'b0000, 4'b0000};
        vecs[15] = '{32'h1000_0000, 1'b1, 4'b0010, 4'b0000};

        s_hrdata    = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
        s_hreadyout = 4'b1111;
        s_hresp     = 4'b0000;
        hreset      = 1'b1;
        drive(32'h0, IDLE, 1'b0);

        // Reset state
        repeat (2) tick();
        check("rst_hready_out", 32'(hready_out), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_cnt", 32'(dec_err_cnt), 32'd0);
        hreset = 1'b0;

        // Combinational decode table (IDLE only, so no errors get raised)
        foreach (vecs[i]) begin
            drive(vecs[i].addr, IDLE, vecs[i].remap);
            check($sformatf("hsel[%0d]", i), 32'(hsel), 32'(vecs[i].exp_hsel));
            check($sformatf("hsel_ovl[%0d]", i), 32'(hsel_ovl), 32'(vecs[i].exp_ovl));
        end
        check("table_cnt", 32'(dec_err_cnt), 32'd0);

        // Pipelined read from slave 1 then slave 2 with 3 wait states
        drive(32'h1000_0010, NONSEQ, 1'b0);
        check("t2_hsel1", 32'(hsel), 32'b0010);
        tick();
        drive(32'h2000_0000, NONSEQ, 1'b0);
        check("t2_hsel2", 32'(hsel), 32'b0100);
        check("t2_rdata1", hrdata, 32'hB1B1_0001);
        check("t2_ready1", 32'(hready_out), 32'd1);
        s_hreadyout[2] = 1'b0;
        tick();
        drive(32'h0, IDLE, 1'b0);
        for (int w = 0; w < 3; w++) begin
            check($sformatf("t2_wait%0d", w), 32'(hready_out), 32'd0);
            if (w < 2) tick();
        end
        s_hreadyout[2] = 1'b1;
        #1;
        check("t2_ready2", 32'(hready_out), 32'd1);
        check("t2_rdata2", hrdata, 32'hC2C2_0002);
        tick();
        check("t2_rdata0", hrdata, 32'hA0A0_0000);

        // Unmapped NONSEQ -> two-cycle ERROR; unmapped IDLE -> zero-wait OKAY
        drive(32'h3000_0000, NONSEQ, 1'b0);
        check("t3_hsel", 32'(hsel), 32'b0000);
        tick();
        exp_cnt++;
        drive(32'h3000_0000, IDLE, 1'b0);
        check("t3_err1_ready", 32'(hready_out), 32'd0);
        check("t3_err1_resp", 32'(hresp), 32'd1);
        check("t3_err1_rdata", hrdata, 32'h0);
        check("t3_cnt", 32'(dec_err_cnt), 32'(exp_cnt));
        tick();
        check("t3_err2_ready", 32'(hready_out), 32'd1);
        check("t3_err2_resp", 32'(hresp), 32'd1);
        tick();
        check("t3_idle_ready", 32'(hready_out), 32'd1);
        check("t3_idle_resp", 32'(hresp), 32'd0);
        tick();
        check("t3_idle2_resp", 32'(hresp), 32'd0);
        check("t3_idle_cnt", 32'(dec_err_cnt), 32'(exp_cnt));

        // Back-to-back unmapped NONSEQ, second accepted in DS_ERR2
        drive(32'h3000_0000, NONSEQ, 1'b0);
        tick();
        exp_cnt++;
        check("t4_a_err1_ready", 32'(hready_out), 32'd0);
        check("t4_a_err1_resp", 32'(hresp), 32'd1);
        tick();
        check("t4_a_err2_ready", 32'(hready_out), 32'd1);
        check("t4_a_err2_resp", 32'(hresp), 32'd1);
        tick();
        exp_cnt++;
        check("t4_b_err1_ready", 32'(hready_out), 32'd0);
        check("t4_b_err1_resp", 32'(hresp), 32'd1);
        check("t4_b_cnt", 32'(dec_err_cnt), 32'(exp_cnt));
        drive(32'h3000_0000, IDLE, 1'b0);
        tick();
        check("t4_b_err2_ready", 32'(hready_out), 32'd1);
        check("t4_b_err2_resp", 32'(hresp), 32'd1);
        tick();
        check("t4_ok_resp", 32'(hresp), 32'd0);
        check("t4_ok_cnt", 32'(dec_err_cnt), 32'(exp_cnt));

        // Remap routes region-0 data phase to slave 1
        drive(32'h0000_0100, NONSEQ, 1'b1);
        check("t5_hsel_remap", 32'(hsel), 32'b0010);
        tick();
        drive(32'h0000_0100, NONSEQ, 1'b0);
        check("t5_hsel_noremap", 32'(hsel), 32'b0001);
        check("t5_rdata_remap", hrdata, 32'hB1B1_0001);
        tick();
        drive(32'h0, IDLE, 1'b0);
        check("t5_rdata_noremap", hrdata, 32'hA0A0_0000);
        tick();

        // Async reset in the middle of DS_ERR1
        drive(32'h3000_0000, NONSEQ, 1'b0);
        tick();
        check("t1_in_err1", 32'(hready_out), 32'd0);
        drive(32'h3000_0000, IDLE, 1'b0);
        #1;
        hreset = 1'b1;
        #1;
        check("t1_async_ready", 32'(hready_out), 32'd1);
        check("t1_async_resp", 32'(hresp), 32'd0);
        check("t1_async_cnt", 32'(dec_err_cnt), 32'd0);
        tick();
        hreset = 1'b0;
        tick();
        check("t1_after_ready", 32'(hready_out), 32'd1);
        check("t1_after_resp", 32'(hresp), 32'd0);
        check("t1_after_rdata", hrdata, 32'h0);
        check("t1_after_cnt", 32'(dec_err_cnt), 32'd0);

        // Counter saturation: after odd tick i the count is (i+1)/2 until it pins at 0xFF
        drive(32'h3000_0000, NONSEQ, 1'b0);
        for (int i = 1; i <= 650; i++) begin
            tick();
            if (i == 507) check("t6_cnt_fe", 32'(dec_err_cnt), 32'h0000_00FE);
            if (i == 509) check("t6_cnt_ff", 32'(dec_err_cnt), 32'h0000_00FF);
        end
        check("t6_cnt_sat", 32'(dec_err_cnt), 32'h0000_00FF);
        check("t6_err2_ready", 32'(hready_out), 32'd1);
        check("t6_err2_resp", 32'(hresp), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
